// File: rtl/tc_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, clock enable and valid tracking.
// The product can be shifted, rounded and then saturated or wrapped, with an overflow flag.
module tc_mul_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 17,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 1,
    parameter int P_WIDTH   = 31,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SATURATE  = 0,
    parameter int NUM_STAGE = 3
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ce,
    input  logic               din_vld,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    output logic               dout_vld,
    output logic [P_WIDTH-1:0] dout,
    output logic               dout_ovf
);

    localparam int FW  = A_WIDTH + B_WIDTH + 2;
    localparam int RW  = FW + 1;
    localparam int EW  = ((RW > P_WIDTH + 1) ? RW : P_WIDTH + 1) + 1;
    localparam int DLY = (NUM_STAGE > 3) ? NUM_STAGE - 3 : 0;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

    localparam logic signed [RW-1:0] RND_ONE = 1;
    localparam logic signed [RW-1:0] RND_ADD =
        ((ROUND != 0) && (SHIFT > 0)) ? (RND_ONE <<< RSH) : '0;
    localparam logic signed [EW-1:0] E_ONE  = 1;
    localparam logic signed [EW-1:0] HI_LIM =
        RES_SIGNED ? ((E_ONE <<< (P_WIDTH - 1)) - E_ONE) : ((E_ONE <<< P_WIDTH) - E_ONE);
    localparam logic signed [EW-1:0] LO_LIM =
        RES_SIGNED ? -(E_ONE <<< (P_WIDTH - 1)) : '0;

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 6) begin : g_bad_stage
            $error("tc_mul_pipe: NUM_STAGE must be in 1..6");
        end
        if (SHIFT < 0 || SHIFT >= A_WIDTH + B_WIDTH) begin : g_bad_shift
            $error("tc_mul_pipe: SHIFT must be in 0..A_WIDTH+B_WIDTH-1");
        end
    endgenerate

    // Operand stage; bypassed when fewer than three stages are requested
    logic [A_WIDTH-1:0] a_s;
    logic [B_WIDTH-1:0] b_s;
    logic               v_s;

    generate
        if (NUM_STAGE >= 3) begin : g_in_reg
            logic [A_WIDTH-1:0] a_reg;
            logic [B_WIDTH-1:0] b_reg;
            logic               v_reg;
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                    v_reg <= 1'b0;
                end else if (ce) begin
                    a_reg <= din0;
                    b_reg <= din1;
                    v_reg <= din_vld;
                end
            end
            assign a_s = a_reg;
            assign b_s = b_reg;
            assign v_s = v_reg;
        end else begin : g_in_comb
            assign a_s = din0;
            assign b_s = din1;
            assign v_s = din_vld;
        end
    endgenerate

    // Both operands widened to the exact product width so the multiply is a plain signed one
    logic               a_fill;
    logic               b_fill;
    logic signed [FW-1:0] a_ext;
    logic signed [FW-1:0] b_ext;
    logic signed [FW-1:0] prod_full;

    always_comb begin
        a_fill    = (A_SIGNED != 0) & a_s[A_WIDTH-1];
        b_fill    = (B_SIGNED != 0) & b_s[B_WIDTH-1];
        a_ext     = {{(FW - A_WIDTH){a_fill}}, a_s};
        b_ext     = {{(FW - B_WIDTH){b_fill}}, b_s};
        prod_full = a_ext * b_ext;
    end

    logic signed [FW-1:0] p_s;
    logic                 pv_s;

    generate
        if (NUM_STAGE >= 2) begin : g_prod_reg
            logic signed [FW-1:0] p_reg;
            logic                 pv_reg;
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    p_reg  <= '0;
                    pv_reg <= 1'b0;
                end else if (ce) begin
                    p_reg  <= prod_full;
                    pv_reg <= v_s;
                end
            end
            assign p_s  = p_reg;
            assign pv_s = pv_reg;
        end else begin : g_prod_comb
            assign p_s  = prod_full;
            assign pv_s = v_s;
        end
    endgenerate

    // One guard bit above the product keeps the rounding add from overflowing
    logic signed [RW-1:0]  rnd;
    logic signed [RW-1:0]  shf;
    logic signed [EW-1:0]  sx;
    logic [P_WIDTH-1:0]    res_d;
    logic                  res_hi;
    logic                  res_lo;

    always_comb begin
        rnd    = {p_s[FW-1], p_s} + RND_ADD;
        shf    = rnd >>> SHIFT;
        sx     = {{(EW - RW){shf[RW-1]}}, shf};
        res_hi = sx > HI_LIM;
        res_lo = sx < LO_LIM;
        res_d  = sx[P_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (res_hi) begin
                res_d = HI_LIM[P_WIDTH-1:0];
            end else if (res_lo) begin
                res_d = LO_LIM[P_WIDTH-1:0];
            end
        end
    end

    // Index 0 is the result register; higher indices are pure output delay
    logic [P_WIDTH-1:0] d_pipe [0:DLY];
    logic               v_pipe [0:DLY];
    logic               o_pipe [0:DLY];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i <= DLY; i++) begin
                d_pipe[i] <= '0;
                v_pipe[i] <= 1'b0;
                o_pipe[i] <= 1'b0;
            end
        end else if (ce) begin
            d_pipe[0] <= res_d;
            v_pipe[0] <= pv_s;
            o_pipe[0] <= res_hi | res_lo;
            for (int i = 1; i <= DLY; i++) begin
                d_pipe[i] <= d_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
                o_pipe[i] <= o_pipe[i-1];
            end
        end
    end

    assign dout     = d_pipe[DLY];
    assign dout_vld = v_pipe[DLY];
    assign dout_ovf = o_pipe[DLY];

endmodule

// File: tb/tb_tc_mul_pipe.sv
// Scoreboard bench for tc_mul_pipe: five configurations share operands and ce,
// each has its own valid input, expected-result queue and output monitor.
module tb_tc_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [4:0]  vld;
    logic [15:0] din0;
    logic [16:0] din1;

    logic [30:0] d0, d1, d2, d3;
    logic [7:0]  d4;
    logic [4:0]  vo;
    logic [4:0]  ovf;
    logic [31:0] dout_a [5];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int exp_d [5][$];
    bit exp_o [5][$];

    always #5 clk = ~clk;

    // 0: defaults (wrap)  1: saturate  2: shift 4 round  3: shift 4 floor  4: 1 stage unsigned 8-bit sat
    tc_mul_pipe u_dut0 (.ap_clk(clk), .ap_rst(rst), .ce(ce), .din_vld(vld[0]), .din0(din0), .din1(din1),
                        .dout_vld(vo[0]), .dout(d0), .dout_ovf(ovf[0]));
    tc_mul_pipe #(.SATURATE(1)) u_dut1 (.ap_clk(clk), .ap_rst(rst), .ce(ce), .din_vld(vld[1]), .din0(din0),
                        .din1(din1), .dout_vld(vo[1]), .dout(d1), .dout_ovf(ovf[1]));
    tc_mul_pipe #(.SHIFT(4), .ROUND(1)) u_dut2 (.ap_clk(clk), .ap_rst(rst), .ce(ce), .din_vld(vld[2]),
                        .din0(din0), .din1(din1), .dout_vld(vo[2]), .dout(d2), .dout_ovf(ovf[2]));
    tc_mul_pipe #(.SHIFT(4), .ROUND(0)) u_dut3 (.ap_clk(clk), .ap_rst(rst), .ce(ce), .din_vld(vld[3]),
                        .din0(din0), .din1(din1), .dout_vld(vo[3]), .dout(d3), .dout_ovf(ovf[3]));
    tc_mul_pipe #(.NUM_STAGE(1), .A_SIGNED(0), .B_SIGNED(0), .P_WIDTH(8), .SATURATE(1)) u_dut4 (
                        .ap_clk(clk), .ap_rst(rst), .ce(ce), .din_vld(vld[4]), .din0(din0), .din1(din1),
                        .dout_vld(vo[4]), .dout(d4), .dout_ovf(ovf[4]));

    assign dout_a[0] = {1'b0, d0};
    assign dout_a[1] = {1'b0, d1};
    assign dout_a[2] = {1'b0, d2};
    assign dout_a[3] = {1'b0, d3};
    assign dout_a[4] = {24'd0, d4};

    function automatic logic [31:0] mask(int k);
        return (k == 4) ? 32'h0000_00ff : 32'h7fff_ffff;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s dut%0d: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      nm, k, act, act, req, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int k, int a, int b, int ed, bit eo);
        din0   = 16'(a);
        din1   = 17'(b);
        vld[k] = 1'b1;
        exp_d[k].push_back(ed);
        exp_o[k].push_back(eo);
        tick();
        vld[k] = 1'b0;
    endtask

    function automatic bit busy();
        for (int k = 0; k < 5; k++) if (exp_d[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_mon
            logic        upd    = 1'b0;
            logic        holdc  = 1'b0;
            logic [31:0] prev_d = '0;
            logic        prev_v = 1'b0;

            // A fresh result exists only after an edge where the pipeline actually advanced
            always @(posedge clk) begin
                upd   <= ce && !rst;
                holdc <= !ce && !rst;
            end

            always @(negedge clk) begin
                int ed;
                bit eo;
                if (upd && vo[gi]) begin
                    if (exp_d[gi].size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_out dut%0d: got dout_vld=1 dout=%0d, expected no output at %0t",
                                 gi, dout_a[gi], $time);
                    end else begin
                        ed = exp_d[gi].pop_front();
                        eo = exp_o[gi].pop_front();
                        chk("dout", gi, dout_a[gi], 32'(ed) & mask(gi));
                        chk("ovf", gi, 32'(ovf[gi]), 32'(eo));
                    end
                end
                if (holdc) begin
                    chk("hold_dout", gi, dout_a[gi], prev_d);
                    chk("hold_vld", gi, 32'(vo[gi]), 32'(prev_v));
                end
                prev_d <= dout_a[gi];
                prev_v <= vo[gi];
            end
        end
    endgenerate

    initial begin
        rst  = 1'b1;
        ce   = 1'b1;
        vld  = '0;
        din0 = '0;
        din1 = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("rst_vld", k, 32'(vo[k]), 32'd0);
            chk("rst_dout", k, dout_a[k], 32'd0);
            chk("rst_ovf", k, 32'(ovf[k]), 32'd0);
        end

        // Wrap: 65535 * -65536 = -4294901760, low 31 bits = 65536
        issue(0, 65535, -65536, 65536, 1'b1);
        tick();
        tick();
        chk("lat3_vld", 0, 32'(vo[0]), 32'd1);
        tick();
        chk("lat3_vld_drop", 0, 32'(vo[0]), 32'd0);

        // Saturate to -2^30, then an in-range product
        issue(1, 65535, -65536, -1073741824, 1'b1);
        issue(1, 1000, -3, -3000, 1'b0);
        repeat (4) tick();

        // Shift by 4: 9 -> 1 rounded / 0 floor, -8 -> 0 rounded / -1 floor
        issue(2, 3, 3, 1, 1'b0);
        issue(2, 1, -8, 0, 1'b0);
        issue(3, 3, 3, 0, 1'b0);
        issue(3, 1, -8, -1, 1'b0);
        repeat (4) tick();

        // Stream (i,-i) with ce pattern 1,0,1,1,0; din_vld stays high while ce=0
        begin
            int i   = 1;
            int cyc = 0;
            while (i <= 8 && cyc < 100) begin
                ce     = (cyc % 5 == 0) || (cyc % 5 == 2) || (cyc % 5 == 3);
                din0   = 16'(i);
                din1   = 17'(-i);
                vld[0] = 1'b1;
                if (ce) begin
                    exp_d[0].push_back(-(i * i));
                    exp_o[0].push_back(1'b0);
                end
                tick();
                if (ce) i++;
                cyc++;
            end
            vld[0] = 1'b0;
            ce     = 1'b1;
            repeat (5) tick();
        end

        // Two results in flight, then reset: both must vanish
        din0   = 16'd7;
        din1   = 17'd9;
        vld[0] = 1'b1;
        tick();
        din0 = 16'd11;
        tick();
        vld[0] = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_vld", 0, 32'(vo[0]), 32'd0);
        chk("midrst_dout", 0, dout_a[0], 32'd0);
        chk("midrst_ovf", 0, 32'(ovf[0]), 32'd0);
        issue(0, 1000, -3, -3000, 1'b0);
        tick();
        tick();
        chk("postrst_lat_vld", 0, 32'(vo[0]), 32'd1);
        repeat (2) tick();

        // Single-stage, unsigned, 8-bit saturating
        issue(4, 20, 20, 255, 1'b1);
        chk("lat1_vld", 4, 32'(vo[4]), 32'd1);
        issue(4, 10, 10, 100, 1'b0);
        chk("lat1_vld_b", 4, 32'(vo[4]), 32'd1);
        tick();

        for (int c = 0; c < 40 && busy(); c++) tick();
        for (int k = 0; k < 5; k++) begin
            if (exp_d[k].size() != 0) begin
                total_cnt++;
                $display("FAIL drain dut%0d: got %0d results still outstanding, expected 0",
                         k, exp_d[k].size());
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tc_mul_pipe.md
Name: tc_mul_pipe

Overview:
- Parametrised, pipelined multiplier for the TrackletCalculator datapath.
- Replaces the fixed-width, purely combinational DSP multiply instances.
- Adds per-operand signedness, configurable pipeline depth, clock enable, valid tracking, and optional post-multiply shift, rounding and saturation with an overflow flag.
- Maps to one DSP48 per instance for operand widths up to 18x25.

Parameters:
- A_WIDTH, 16, width of din0.
- B_WIDTH, 17, width of din1.
- A_SIGNED, 0, 1 = din0 is two's complement; 0 = unsigned.
- B_SIGNED, 1, 1 = din1 is two's complement; 0 = unsigned.
- P_WIDTH, 31, width of dout.
- SHIFT, 0, number of LSBs dropped from the full product (0..A_WIDTH+B_WIDTH-1).
- ROUND, 0, 1 = round half up before dropping LSBs. Ignored when SHIFT=0.
- SATURATE, 0, 1 = clamp to P_WIDTH range; 0 = wrap (truncate MSBs).
- NUM_STAGE, 3, register stages from input to output (1..6).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous reset, active high.
- ce  in  1  clock enable; low freezes every pipeline register.
- din_vld  in  1  din0/din1 valid this cycle.
- din0  in  A_WIDTH  operand A.
- din1  in  B_WIDTH  operand B.
- dout_vld  out  1  dout valid.
- dout  out  P_WIDTH  result.
- dout_ovf  out  1  result was saturated (SATURATE=1) or wrapped (SATURATE=0).

Behaviour:
- Reset: one clock with ap_rst=1 clears every pipeline register. dout=0, dout_vld=0, dout_ovf=0 on the following cycle. Reset wins over ce.
- Reset mid-operation discards all in-flight data. No output of pre-reset data afterwards.
- Signedness of the result: signed if A_SIGNED or B_SIGNED, else unsigned.
- Full product:
  - Extend each operand by one bit: sign-extend if signed, zero-extend if unsigned.
  - Multiply as signed, giving an exact result of A_WIDTH+B_WIDTH+2 bits.
- Rounding: if ROUND=1 and SHIFT>0, add 2^(SHIFT-1) to the full product. The addition must not overflow (use one guard bit).
- Shift: arithmetic right shift by SHIFT (floor for negative values).
- Range reduction to P_WIDTH:
  - SATURATE=1: clamp to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1] for a signed result, or [0, 2^P_WIDTH-1] for unsigned.
  - SATURATE=0: keep the low P_WIDTH bits.
  - dout_ovf=1 whenever the shifted value lies outside that range. It is aligned with the dout it describes.
- Latency: with ce held high, inputs sampled at edge t appear on dout/dout_vld/dout_ovf after edge t+NUM_STAGE-1. NUM_STAGE=1 means registered output only.
- Stage allocation (for DSP inference):
  - Stage 1: input registers.
  - Stage 2: product register.
  - Stage 3: round/shift/saturate register.
  - Stages beyond 3: delay registers on the output.
  - For NUM_STAGE<3, merge stages from the input side; the output is always registered.
- Clock enable: with ce=0, all data and valid registers hold, including dout_vld. No bubbles are inserted and nothing is lost. din_vld is ignored while ce=0.
- Data registers load regardless of din_vld. Only dout_vld tracks validity. dout content is unspecified when dout_vld=0.
- Back-to-back: one result per ce cycle; throughput 1.
- Parameter checks: NUM_STAGE outside 1..6, or SHIFT >= A_WIDTH+B_WIDTH, is an elaboration error.

Test Plan:
- Defaults, ce=1, din0=65535, din1=-65536, one valid pulse -> after 3 edges: dout_vld=1, dout=65536 (wrapped), dout_ovf=1. Next cycle dout_vld=0.
- Same stimulus with SATURATE=1 -> dout=-1073741824, dout_ovf=1. Then din0=1000, din1=-3 -> dout=-3000, dout_ovf=0.
- SHIFT=4, ROUND=1: (3,3) -> 1; (1,-8) -> 0. With ROUND=0: (3,3) -> 0; (1,-8) -> -1. dout_ovf=0 in all four cases.
- Stream 8 consecutive valid pairs (i, -i) for i=1..8 with ce toggling 1,0,1,1,0,... -> dout outputs -1,-4,...,-64 in order, with no drops or duplicates. The output holds during every ce=0 cycle.
- Assert ap_rst for one cycle while 2 results are in flight -> no dout_vld for those results. dout=0, dout_vld=0, dout_ovf=0 on the cycle after reset. Next input emerges with normal latency.
- NUM_STAGE=1, A_SIGNED=0, B_SIGNED=0, P_WIDTH=8, SATURATE=1: (20,20) -> dout=255, dout_ovf=1 after one edge. (10,10) -> dout=100, dout_ovf=0.
